clk_div_prog: RTL
=================

// Module: clk_div_prog
// PURPOSE
//  Programmable clock-enable/divider; successor to the fixed divide-by-50 toggler.
//  Produces a divided square wave or a periodic single-cycle strobe from clk.
//  Runtime-loadable divisor, count enable and mode select.
//  Feeds the seconds/blink timing chain of the alarm datapath.
// PARAMETERS
//  CNT_W       26  width of divisor and internal counter (max count 2^CNT_W-1)
//  DEFAULT_DIV 25  divisor loaded at reset; 25 reproduces the legacy cadence
// PORTS
//  clk     in   1      system clock; all logic on rising edge
//  rst     in   1      synchronous reset, active-high
//  en      in   1      count enable; 0 freezes counter and out
//  mode    in   1      0 = toggle (50% square), 1 = pulse (1-cycle strobe)
//  load    in   1      1-cycle strobe: capture div_in as new divisor
//  div_in  in   CNT_W  new divisor value, sampled when load=1
//  out     out  1      divided output (square or strobe per mode), registered
//  tick    out  1      1-cycle pulse on every terminal count, registered
//  div_q   out  CNT_W  currently active divisor (readback)
// BEHAVIOUR
//  Reset (rst=1 at posedge): cnt=0, out=0, tick=0, div_q=DEFAULT_DIV, mode_q=0.
//   rst overrides all other inputs in the same cycle.
//  Counter: cnt runs 0..div_q-1 while en=1; terminal condition T = en & (cnt==div_q-1).
//  On T: cnt<=0; tick<=1 next cycle; else tick<=0.
//   Toggle mode: out<=~out on T; period = 2*div_q clk cycles, 50% duty.
//   Pulse mode: out<=T (identical to tick); high 1 cycle per div_q cycles.
//  en=0: cnt and out (toggle mode) hold; tick<=0; pulse-mode out<=0.
//  First tick after reset with en=1 continuously: tick high in cycle div_q
//   (counting first cycle after reset release as cycle 1).
//  Load: if load=1, div_q<=(div_in==0 ? 1 : div_in); cnt<=0; no T evaluated
//   that cycle (load wins over terminal count; tick<=0, out holds).
//   Load is honoured regardless of en.
//  div_q==1: T every enabled cycle; toggle mode gives clk/2, pulse mode out stays 1.
//  Mode change: mode registered into mode_q; when mode!=mode_q: cnt<=0, out<=0,
//   tick<=0, mode_q<=mode. Takes effect on the cycle of change (no T that cycle).
//   Priority: rst > load > mode change > count.
//   Simultaneous load and mode change: both applied (div_q updated, out<=0, cnt<=0).
//  Counter width: cnt compare is unsigned CNT_W-bit; no wrap possible because
//   cnt<=div_q-1 <= 2^CNT_W-2.
//  Reset mid-period: count restarts from 0, out returns to 0, div_q back to default.
//  No combinational path from inputs to outputs.
// TESTING
//  1 rst 3 cycles, en=1 mode=0, DEFAULT_DIV=25 -> out rises at cycle 25, falls at 50,
//    tick high exactly cycles 25,50,75; div_q=25.
//  2 load=1 div_in=4 mid-count, en=1 mode=1 -> div_q=4; out/tick high every 4th
//    cycle starting 4 cycles after load; no pulse in load cycle.
//  3 load div_in=0 -> div_q reads 1; mode=0 gives out toggling every cycle.
//  4 en low for 10 cycles at cnt=7 (div 25) -> out/cnt frozen, tick=0; resume ->
//    next tick 18 enabled cycles later.
//  5 load and terminal count same cycle -> no toggle, no tick, cnt=0, new div_q.
//  6 mode 0->1 while out=1 -> out=0, cnt=0 same edge; rst asserted mid-period ->
//    next cycle out=0, tick=0, div_q=25.

Source files
------------

// File: rtl/clk_div_prog.sv
// clk_div_prog: programmable divider giving a 50% square wave or a periodic strobe, plus a terminal-count tick
module clk_div_prog #(
   parameter int CNT_W       = 26,
   parameter int DEFAULT_DIV = 25
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             mode,
   input  logic             load,
   input  logic [CNT_W-1:0] div_in,
   output logic             out,
   output logic             tick,
   output logic [CNT_W-1:0] div_q
);
   logic [CNT_W-1:0] cnt_q, cnt_d, div_d;
   logic out_q, out_d, tick_q, tick_d, mode_q, mode_d, term;
   always_comb begin
      term   = en && (cnt_q == div_q - 1'b1);
      cnt_d  = cnt_q;
      out_d  = out_q;
      tick_d = 1'b0;
      div_d  = div_q;
      mode_d = mode;
      if (load || mode != mode_q) begin
         cnt_d = '0;
         if (load) div_d = (div_in == '0) ? CNT_W'(1) : div_in;
         if (mode != mode_q) out_d = 1'b0;
      end else if (en) begin
         cnt_d  = term ? '0 : cnt_q + 1'b1;
         tick_d = term;
         out_d  = mode_q ? term : out_q ^ term;
      end else if (mode_q) out_d = 1'b0;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q  <= '0;
         out_q  <= 1'b0;
         tick_q <= 1'b0;
         div_q  <= CNT_W'(DEFAULT_DIV);
         mode_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         out_q  <= out_d;
         tick_q <= tick_d;
         div_q  <= div_d;
         mode_q <= mode_d;
      end
   end
   assign out  = out_q;
   assign tick = tick_q;
endmodule
